// File: rtl/rtc_time_counter.sv
// rtc_time_counter
//   Stopwatch time base. A prescaler divides i_sclk down to a hundredth-second
//   tick. Each tick advances a six-digit BCD live count (MM:SS.hh), which wraps
//   from 59:59.99 to 00:00.00. A display register follows the live count one
//   cycle behind, or holds while a lap is latched.
//
// Ports
//   i_sclk        system clock, rising-edge active
//   i_reset_n     asynchronous active-low reset
//   i_countinit   synchronous clear of prescaler, live count and display
//   i_countenb    1 = run, 0 = pause (the partial tick is kept)
//   i_latchcount  1 = freeze the display (lap hold); the live count keeps going
//   o_min_tens .. o_hund_ones  BCD display digits, straight from the display register
//   o_rollover    one-cycle pulse when the live count wraps from 59:59.99
module rtc_time_counter #(
  parameter int P_TICK_DIV = 100000
) (
  input  logic       i_sclk,
  input  logic       i_reset_n,
  input  logic       i_countinit,
  input  logic       i_countenb,
  input  logic       i_latchcount,
  output logic [3:0] o_min_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_sec_ones,
  output logic [3:0] o_hund_tens,
  output logic [3:0] o_hund_ones,
  output logic       o_rollover
);

  localparam int                 PRESC_W   = (P_TICK_DIV > 1) ? $clog2(P_TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(P_TICK_DIV - 1);

  // Per-digit upper limits, packed in the same order as the count registers:
  // {min_tens, min_ones, sec_tens, sec_ones, hund_tens, hund_ones}.
  localparam logic [23:0] DIGIT_LIM = 24'h595999;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [23:0]        live_q,  live_d;
  logic [23:0]        disp_q,  disp_d;
  logic               roll_q,  roll_d;

  logic               tick;
  logic               carry;
  logic [3:0]         digit;
  logic [3:0]         lim;

  always_comb begin
    presc_d = presc_q;
    live_d  = live_q;
    disp_d  = disp_q;
    roll_d  = 1'b0;
    tick    = 1'b0;
    carry   = 1'b0;
    digit   = 4'd0;
    lim     = 4'd0;

    if (i_countinit) begin
      presc_d = '0;
      live_d  = '0;
      disp_d  = '0;
    end else begin
      if (i_countenb) begin
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          tick    = 1'b1;
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end

      // Ripple the tick through the digits from hund_ones upwards. A digit at
      // (or, defensively, above) its limit wraps to 0 and passes the carry on.
      carry = tick;
      for (int i = 0; i < 6; i++) begin
        digit = live_q[i*4 +: 4];
        lim   = DIGIT_LIM[i*4 +: 4];
        if (carry) begin
          if (digit >= lim) begin
            live_d[i*4 +: 4] = 4'd0;
          end else begin
            live_d[i*4 +: 4] = digit + 4'd1;
            carry            = 1'b0;
          end
        end
      end
      // A carry out of min_tens means the whole count just wrapped.
      roll_d = carry;

      // Loading the pre-update live value gives the one-cycle display lag.
      if (!i_latchcount) begin
        disp_d = live_q;
      end
    end
  end

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_q <= '0;
      live_q  <= '0;
      disp_q  <= '0;
      roll_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      live_q  <= live_d;
      disp_q  <= disp_d;
      roll_q  <= roll_d;
    end
  end

  assign o_min_tens  = disp_q[23:20];
  assign o_min_ones  = disp_q[19:16];
  assign o_sec_tens  = disp_q[15:12];
  assign o_sec_ones  = disp_q[11:8];
  assign o_hund_tens = disp_q[7:4];
  assign o_hund_ones = disp_q[3:0];
  assign o_rollover  = roll_q;

endmodule

// File: doc/rtc_time_counter.md
RTC_TIME_COUNTER -- requirements
Module: rtc_time_counter

Interface
REQ-001 The block SHALL have parameter P_TICK_DIV, default 100000, giving i_sclk cycles per hundredth-second tick; legal values are 2 or more.
REQ-002 The block SHALL have port i_sclk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port i_countinit, input, 1 bit: synchronous clear request from trigger detection.
REQ-005 The block SHALL have port i_countenb, input, 1 bit: count enable from trigger detection (1 = run, 0 = pause).
REQ-006 The block SHALL have port i_latchcount, input, 1 bit: display freeze (lap hold) from trigger detection.
REQ-007 The block SHALL have ports o_min_tens, o_min_ones, o_sec_tens, o_sec_ones, o_hund_tens, o_hund_ones, each output, 4 bits: BCD display digits in MM:SS.hh order.
REQ-008 The block SHALL have port o_rollover, output, 1 bit: one-cycle pulse on wrap from 59:59.99.

Function
REQ-009 The block SHALL hold a prescaler of width clog2(P_TICK_DIV), a live BCD count (six digits) and a display register (six digits).
REQ-010 Prescaler: when i_countenb=1 and i_countinit=0 it SHALL increment; when it equals P_TICK_DIV-1 it SHALL return to 0 and assert an internal tick for that cycle.
REQ-011 When i_countenb=0 the prescaler and the live count SHALL hold their values; a pause keeps the partial tick.
REQ-012 On each tick the live count SHALL increment by 0.01 s at the next rising edge.
REQ-013 Digit limits: hund_ones and hund_tens 0-9, sec_ones 0-9, sec_tens 0-5, min_ones 0-9, min_tens 0-5.
REQ-014 Each digit SHALL carry into the next digit when it wraps.
REQ-015 No digit SHALL ever hold a value above its limit.
REQ-016 A tick at 59:59.99 SHALL set the live count to 00:00.00 and assert o_rollover for exactly one cycle.
REQ-017 o_rollover SHALL be 0 at all other times.
REQ-018 When i_latchcount=0 the display register SHALL load the live count every cycle, i.e. the display lags the live count by one cycle.
REQ-019 When i_latchcount=1 the display register SHALL hold its value while the live count continues per REQ-010 to REQ-016.
REQ-020 On the first cycle with i_latchcount back at 0, the display SHALL reload the current live count.
REQ-021 i_countinit=1 SHALL clear the prescaler, live count and display register to zero at the next edge, regardless of i_countenb or i_latchcount.
REQ-022 While i_countinit=1, o_rollover SHALL be 0.
REQ-023 Priority SHALL be: reset, then i_countinit, then tick/enable; the latch controls only the display register.
REQ-024 The o_* digits SHALL be driven directly from the display register, with no combinational path from inputs to outputs.

Reset
REQ-025 While i_reset_n=0, the prescaler, all live digits, all display digits and o_rollover SHALL be 0 immediately, without waiting for a clock edge.
REQ-026 Deassertion of i_reset_n SHALL take effect at the next rising i_sclk edge.
REQ-027 Reset asserted mid-count or mid-latch SHALL discard all state.
REQ-028 After reset deassertion with i_countenb=0, all outputs SHALL remain 0.

Verification (P_TICK_DIV=4, 10 ns clock)
REQ-029 Assert i_reset_n=0 mid-count -> all digits are 0 and o_rollover=0 within the same timestep.
REQ-030 Release reset, set i_countenb=1 for 40 cycles, then 0 -> display reads 00:00.10 (hund_tens=1, hund_ones=0) and stays there.
REQ-031 Pause and resume: i_countenb=1 for 2 cycles, 0 for 20 cycles, 1 for 2 cycles -> exactly one increment, to 00:00.01 (partial tick preserved).
REQ-032 Latch test: at 00:00.10 set i_latchcount=1 and run 40 cycles -> display holds 00:00.10; clear i_latchcount -> display shows 00:00.20 one cycle later.
REQ-033 Run from zero for 1,440,000 enabled cycles -> display passes 59:59.99 then 00:00.00, o_rollover high exactly one cycle, sec_tens never above 5.
REQ-034 Assert i_countinit=1 together with i_countenb=1 and i_latchcount=1 at 00:00.37 -> next edge: all digits 0, prescaler 0, o_rollover=0.
